// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state values and default miss timeout.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DMISS  = 2'd1,
        IMISS  = 2'd2,
        BUBBLE = 2'd3
    } hazState_t;

    localparam int DEFAULT_MISS_TIMEOUT = 64;
    localparam int MISS_CNT_W           = 8;

    function automatic logic isMiss(input hazState_t s);
        return (s == DMISS) || (s == IMISS);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard status in / stage-register enables out. stallCycles is present only with HAZARD_PERF_EN.
interface pipeline_hazard_controller_if
`ifdef HAZARD_PERF_EN
    #(parameter int PERF_W = 32)
`endif
    ;
    logic       iHit;
    logic       dReq;
    logic       dHit;
    logic [4:0] ifIdRs;
    logic [4:0] ifIdRt;
    logic [4:0] idExRt;
    logic       idExMemRead;
    logic       branchTaken;
    logic       jumpSignal;

    logic       pcWrite;
    logic       ifIdWrite;
    logic       idExHit;
    logic       exMemWrite;
    logic       memWbWrite;
    logic       ifIdFlush;
    logic       idExFlush;
    logic       missTimeout;
    logic [1:0] state;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stallCycles;

    modport master (
        output iHit, dReq, dHit, ifIdRs, ifIdRt, idExRt, idExMemRead, branchTaken, jumpSignal,
        input  pcWrite, ifIdWrite, idExHit, exMemWrite, memWbWrite, ifIdFlush, idExFlush,
        input  missTimeout, state, stallCycles
    );
    modport slave (
        input  iHit, dReq, dHit, ifIdRs, ifIdRt, idExRt, idExMemRead, branchTaken, jumpSignal,
        output pcWrite, ifIdWrite, idExHit, exMemWrite, memWbWrite, ifIdFlush, idExFlush,
        output missTimeout, state, stallCycles
    );
`else
    modport master (
        output iHit, dReq, dHit, ifIdRs, ifIdRt, idExRt, idExMemRead, branchTaken, jumpSignal,
        input  pcWrite, ifIdWrite, idExHit, exMemWrite, memWbWrite, ifIdFlush, idExFlush,
        input  missTimeout, state
    );
    modport slave (
        input  iHit, dReq, dHit, ifIdRs, ifIdRt, idExRt, idExMemRead, branchTaken, jumpSignal,
        output pcWrite, ifIdWrite, idExHit, exMemWrite, memWbWrite, ifIdFlush, idExFlush,
        output missTimeout, state
    );
`endif

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in ID/EX writes a register the ID instruction reads.
module load_use_detect (
    input  logic       idExMemRead,
    input  logic [4:0] idExRt,
    input  logic [4:0] ifIdRs,
    input  logic [4:0] ifIdRt,
    output logic       loadUse
);

    // $zero is never a real dependency.
    assign loadUse = idExMemRead && (idExRt != 5'd0) &&
                     ((idExRt == ifIdRs) || (idExRt == ifIdRt));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: RUN/DMISS/IMISS/BUBBLE FSM, miss timeout,
// and an optional stall counter enabled by HAZARD_PERF_EN.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int MISS_TIMEOUT = DEFAULT_MISS_TIMEOUT,
    parameter int PERF_W       = 32
) (
    input  logic                          clock,
    input  logic                          resetN,
    pipeline_hazard_controller_if.slave   hz
);

    localparam logic [MISS_CNT_W-1:0] TIMEOUT_CNT = MISS_CNT_W'(MISS_TIMEOUT - 1);
    localparam logic [MISS_CNT_W-1:0] CNT_MAX     = {MISS_CNT_W{1'b1}};

    if (MISS_TIMEOUT < 2 || MISS_TIMEOUT > 255 || PERF_W < 1) begin : gBadParam
        $error("pipeline_hazard_controller: parameter out of range");
    end

    hazState_t             stateQ;
    hazState_t             stateD;
    logic [MISS_CNT_W-1:0] missCnt;
    logic                  missTimeoutQ;
    logic                  loadUse;
    logic                  pcWr, ifIdWr, idExWr, exMemWr, memWbWr;
    logic                  ifIdFl, idExFl;

    load_use_detect uLoadUse (
        .idExMemRead (hz.idExMemRead),
        .idExRt      (hz.idExRt),
        .ifIdRs      (hz.ifIdRs),
        .ifIdRt      (hz.ifIdRt),
        .loadUse     (loadUse)
    );

    always_comb begin
        stateD  = RUN;
        pcWr    = 1'b1;
        ifIdWr  = 1'b1;
        idExWr  = 1'b1;
        exMemWr = 1'b1;
        memWbWr = 1'b1;
        ifIdFl  = 1'b0;
        idExFl  = 1'b0;
        if (hz.dReq && !hz.dHit) begin
            // Freeze everything; a pending branch stays in EX/MEM and is taken after the miss.
            pcWr    = 1'b0;
            ifIdWr  = 1'b0;
            idExWr  = 1'b0;
            exMemWr = 1'b0;
            memWbWr = 1'b0;
            stateD  = DMISS;
        end else if (hz.branchTaken || hz.jumpSignal) begin
            ifIdFl = 1'b1;
            idExFl = 1'b1;
            stateD = RUN;
        end else if (loadUse && (stateQ != BUBBLE)) begin
            pcWr   = 1'b0;
            ifIdWr = 1'b0;
            idExFl = 1'b1;
            stateD = BUBBLE;
        end else if (!hz.iHit) begin
            pcWr   = 1'b0;
            ifIdWr = 1'b0;
            idExFl = 1'b1;
            stateD = IMISS;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateQ       <= RUN;
            missCnt      <= '0;
            missTimeoutQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            // DMISS->IMISS keeps counting: it is one continuous miss from the pipeline's view.
            if ((stateD == RUN) || (stateD == BUBBLE)) begin
                missCnt <= '0;
            end else if (isMiss(stateQ) && (missCnt != CNT_MAX)) begin
                missCnt <= missCnt + 1'b1;
            end
            if (isMiss(stateQ) && (missCnt == TIMEOUT_CNT)) begin
                missTimeoutQ <= 1'b1;
            end
        end
    end

    assign hz.pcWrite     = resetN & pcWr;
    assign hz.ifIdWrite   = resetN & ifIdWr;
    assign hz.idExHit     = resetN & idExWr;
    assign hz.exMemWrite  = resetN & exMemWr;
    assign hz.memWbWrite  = resetN & memWbWr;
    assign hz.ifIdFlush   = resetN & ifIdFl;
    assign hz.idExFlush   = resetN & idExFl;
    assign hz.missTimeout = missTimeoutQ;
    assign hz.state       = stateQ;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stallCnt;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stallCnt <= '0;
        end else if (!pcWr) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign hz.stallCycles = stallCnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MISS_TIMEOUT=4); stallCycles checks need HAZARD_PERF_EN.
module tb_pipeline_hazard_controller;

    logic clock;
    logic resetN;
    int   errors = 0;
    int   checks = 0;

`ifdef HAZARD_PERF_EN
    pipeline_hazard_controller_if #(.PERF_W(32)) hz ();
`else
    pipeline_hazard_controller_if hz ();
`endif

    pipeline_hazard_controller #(.MISS_TIMEOUT(4), .PERF_W(32)) dut (
        .clock  (clock),
        .resetN (resetN),
        .hz     (hz)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Driver tasks
    task automatic clearInputs();
        hz.iHit        = 1'b1;
        hz.dReq        = 1'b0;
        hz.dHit        = 1'b0;
        hz.ifIdRs      = 5'd0;
        hz.ifIdRt      = 5'd0;
        hz.idExRt      = 5'd0;
        hz.idExMemRead = 1'b0;
        hz.branchTaken = 1'b0;
        hz.jumpSignal  = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    // Checkers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {pcWrite, ifIdWrite, idExHit, exMemWrite, memWbWrite}, flushes as {ifIdFlush, idExFlush}.
    task automatic checkOut(input string tag, input logic [4:0] expEn, input logic [1:0] expFl,
                            input logic [1:0] expState);
        check({tag, ".en"}, 32'({hz.pcWrite, hz.ifIdWrite, hz.idExHit, hz.exMemWrite, hz.memWbWrite}),
              32'(expEn));
        check({tag, ".flush"}, 32'({hz.ifIdFlush, hz.idExFlush}), 32'(expFl));
        check({tag, ".state"}, 32'(hz.state), 32'(expState));
    endtask

    task automatic checkStall(input string tag, input logic [31:0] exp);
`ifdef HAZARD_PERF_EN
        check(tag, hz.stallCycles, exp);
`else
        if (exp == 32'hFFFF_FFFF) $display("unused %s", tag);
`endif
    endtask

    initial begin
        resetN = 1'b0;
        clearInputs();
        #2;
        checkOut("reset", 5'b00000, 2'b00, 2'd0);
        check("reset.timeout", 32'(hz.missTimeout), 32'd0);
        checkStall("reset.stall", 32'd0);
        #1 resetN = 1'b1;
        settle();
        checkOut("first", 5'b11111, 2'b00, 2'd0);

        // Load-use through rs: one bubble, held inputs masked while in BUBBLE
        nextCycle(); hz.idExMemRead = 1'b1; hz.idExRt = 5'd8; hz.ifIdRs = 5'd8;
        settle(); checkOut("lu.stall", 5'b00111, 2'b01, 2'd0);
        nextCycle();
        settle(); checkOut("lu.bubble", 5'b11111, 2'b00, 2'd3);
        checkStall("lu.stallcnt", 32'd1);
        nextCycle(); clearInputs();
        settle(); checkOut("lu.run", 5'b11111, 2'b00, 2'd0);

        // Three-cycle I-miss; the hit cycle already runs
        nextCycle(); hz.iHit = 1'b0;
        settle(); checkOut("im.1", 5'b00111, 2'b01, 2'd0);
        nextCycle();
        settle(); checkOut("im.2", 5'b00111, 2'b01, 2'd2);
        nextCycle();
        settle(); checkOut("im.3", 5'b00111, 2'b01, 2'd2);
        nextCycle(); hz.iHit = 1'b1;
        settle(); checkOut("im.hit", 5'b11111, 2'b00, 2'd2);
        checkStall("perf.total", 32'd4);
        nextCycle();
        settle(); checkOut("im.run", 5'b11111, 2'b00, 2'd0);

        // $zero destination never stalls
        nextCycle(); hz.idExMemRead = 1'b1; hz.idExRt = 5'd0; hz.ifIdRs = 5'd0; hz.ifIdRt = 5'd0;
        settle(); checkOut("zero", 5'b11111, 2'b00, 2'd0);

        // Load-use through rt
        nextCycle(); hz.idExRt = 5'd5; hz.ifIdRs = 5'd3; hz.ifIdRt = 5'd5;
        settle(); checkOut("lurt.stall", 5'b00111, 2'b01, 2'd0);
        nextCycle(); clearInputs();
        settle(); checkOut("lurt.bubble", 5'b11111, 2'b00, 2'd3);
        nextCycle();
        settle(); checkOut("lurt.run", 5'b11111, 2'b00, 2'd0);

        // D-miss with a taken branch: freeze three cycles, then flush
        for (int i = 0; i < 3; i++) begin
            nextCycle(); hz.dReq = 1'b1; hz.dHit = 1'b0; hz.branchTaken = 1'b1;
            settle(); checkOut($sformatf("dm.frozen%0d", i), 5'b00000, 2'b00, (i == 0) ? 2'd0 : 2'd1);
        end
        nextCycle(); hz.dHit = 1'b1;
        settle(); checkOut("dm.branch", 5'b11111, 2'b11, 2'd1);
        nextCycle(); clearInputs();
        settle(); checkOut("dm.run", 5'b11111, 2'b00, 2'd0);

        // Jump overrides an I-miss
        nextCycle(); hz.jumpSignal = 1'b1; hz.iHit = 1'b0;
        settle(); checkOut("jmp", 5'b11111, 2'b11, 2'd0);
        nextCycle(); clearInputs();
        settle(); checkOut("jmp.run", 5'b11111, 2'b00, 2'd0);

        // Load-use together with I-miss: bubble first, then the miss
        nextCycle(); hz.idExMemRead = 1'b1; hz.idExRt = 5'd8; hz.ifIdRs = 5'd8; hz.iHit = 1'b0;
        settle(); checkOut("luim.stall", 5'b00111, 2'b01, 2'd0);
        nextCycle(); hz.idExMemRead = 1'b0; hz.idExRt = 5'd0; hz.ifIdRs = 5'd0;
        settle(); checkOut("luim.imiss", 5'b00111, 2'b01, 2'd3);
        nextCycle(); hz.iHit = 1'b1;
        settle(); checkOut("luim.hit", 5'b11111, 2'b00, 2'd2);
        nextCycle();
        settle(); checkOut("luim.run", 5'b11111, 2'b00, 2'd0);

        // Timeout: rises after the 4th IMISS cycle and is sticky
        nextCycle(); hz.iHit = 1'b0;
        settle(); checkOut("to.enter", 5'b00111, 2'b01, 2'd0);
        check("to.enter.flag", 32'(hz.missTimeout), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            settle();
            check($sformatf("to.miss%0d.state", i), 32'(hz.state), 32'd2);
            check($sformatf("to.miss%0d.flag", i), 32'(hz.missTimeout), 32'd0);
        end
        nextCycle();
        settle();
        check("to.set.flag", 32'(hz.missTimeout), 32'd1);
        check("to.set.state", 32'(hz.state), 32'd2);
        nextCycle(); hz.iHit = 1'b1;
        settle(); checkOut("to.hit", 5'b11111, 2'b00, 2'd2);
        check("to.hit.flag", 32'(hz.missTimeout), 32'd1);
        nextCycle();
        settle(); checkOut("to.run", 5'b11111, 2'b00, 2'd0);
        check("to.sticky.flag", 32'(hz.missTimeout), 32'd1);

        // Reset in the middle of a D-miss
        for (int i = 0; i < 5; i++) begin
            nextCycle(); hz.dReq = 1'b1; hz.dHit = 1'b0;
            settle(); checkOut($sformatf("rst.miss%0d", i), 5'b00000, 2'b00, (i == 0) ? 2'd0 : 2'd1);
        end
        #2 resetN = 1'b0; hz.dReq = 1'b0; hz.branchTaken = 1'b1;
        #1;
        checkOut("rst.async", 5'b00000, 2'b00, 2'd0);
        check("rst.async.flag", 32'(hz.missTimeout), 32'd0);
        checkStall("rst.async.stall", 32'd0);
        nextCycle();
        checkOut("rst.held", 5'b00000, 2'b00, 2'd0);
        clearInputs();
        resetN = 1'b1;
        settle();
        checkOut("rst.release", 5'b11111, 2'b00, 2'd0);
        check("rst.release.flag", 32'(hz.missTimeout), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
